// File: rtl/benes_pkg.sv
// Shared definitions for the 16x16 Benes network, its stage modules and the
// configuration loader.
package benes_pkg;

    localparam int N_PORTS  = 16;
    localparam int N_STAGES = 7;
    localparam int N_SW     = 8;
    localparam int SIDX_W   = $clog2(N_STAGES);

    typedef logic [N_SW-1:0] sw_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_t;

endpackage

// File: rtl/benes_cfg_loader.sv
// Double-buffered switch-configuration loader for the Benes network.
// Words land in a shadow bank. A complete load is copied to the active bank
// (switch_set) on a single edge, so the network never sees a partial update.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing loaded since the last commit or abort
// LOAD   | at least one stage word held in the shadow bank
// COMMIT | complete load waiting for net_busy to drop before the copy
module benes_cfg_loader #(
    parameter int N_STAGES = benes_pkg::N_STAGES,
    parameter int N_SW     = benes_pkg::N_SW,
    parameter int SIDX_W   = $clog2(N_STAGES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SIDX_W-1:0]   cfg_stage,
    input  logic [N_SW-1:0]     cfg_data,
    input  logic                cfg_last,
    input  logic                net_busy,
    output benes_pkg::sw_word_t switch_set [N_STAGES-1:0],
    output logic                cfg_done,
    output logic                cfg_err
);
    import benes_pkg::*;

    // One extra bit so an all-ones index can be compared against the count.
    localparam logic [SIDX_W:0] STAGE_LIMIT = (SIDX_W+1)'(N_STAGES);

    cfg_state_t          state;
    sw_word_t            shadow [N_STAGES-1:0];
    logic [N_STAGES-1:0] loaded;
    logic [N_STAGES-1:0] stage_bit;
    logic [N_STAGES-1:0] loaded_nxt;
    logic                fire;
    logic                stage_ok;
    logic                commit_now;

    assign cfg_ready  = (state != COMMIT);
    assign fire       = cfg_valid & cfg_ready;
    assign stage_ok   = ({1'b0, cfg_stage} < STAGE_LIMIT);
    assign loaded_nxt = loaded | stage_bit;
    assign commit_now = (state == COMMIT) & ~net_busy;

    // One-hot decode of the addressed stage (all zero for an out-of-range index).
    always_comb begin
        stage_bit = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            stage_bit[i] = (cfg_stage == SIDX_W'(i));
        end
    end

    // Shadow bank: written by every accepted in-range word, never cleared by aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                shadow[i] <= '0;
            end
        end else if (fire && stage_ok) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (stage_bit[i]) begin
                    shadow[i] <= cfg_data;
                end
            end
        end
    end

    // Load sequencing, completeness tracking, error flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            loaded   <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (fire) begin
                        // A fresh load clears the previous error; a new error below wins.
                        if (state == IDLE) begin
                            cfg_err <= 1'b0;
                        end
                        if (!stage_ok) begin
                            cfg_err <= 1'b1;
                            loaded  <= '0;
                            state   <= IDLE;
                        end else if (cfg_last) begin
                            if (&loaded_nxt) begin
                                loaded <= loaded_nxt;
                                state  <= COMMIT;
                            end else begin
                                cfg_err <= 1'b1;
                                loaded  <= '0;
                                state   <= IDLE;
                            end
                        end else begin
                            loaded <= loaded_nxt;
                            state  <= LOAD;
                        end
                    end
                end
                COMMIT: begin
                    if (!net_busy) begin
                        cfg_done <= 1'b1;
                        loaded   <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Active bank: every stage is replaced on the same commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                switch_set[i] <= '0;
            end
        end else if (commit_now) begin
            for (int i = 0; i < N_STAGES; i++) begin
                switch_set[i] <= shadow[i];
            end
        end
    end

endmodule
